prog_loader: RTL and testbench

Serial program loader sitting directly upstream of the 16-bit x 4096-word instruction/data RAM. It consumes a byte stream from the UART receiver, assembles big-endian 16-bit words, and writes them to consecutive RAM addresses from 0 through the RAM's data/wren/address port. It holds the CPU stopped (`cpu_run` low) until a complete, checksum-verified image has been written.

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-in / word-out bundle between the UART receiver, the program loader and
// the instruction RAM write port, plus the loader's status and CPU-release lines.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] ram_data;
  logic [11:0] ram_addr;
  logic        ram_wren;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_run;

  modport master (
    input  rx_data, rx_valid,
    output ram_data, ram_addr, ram_wren, busy, done, error, cpu_run
  );

  modport slave (
    output rx_data, rx_valid,
    input  ram_data, ram_addr, ram_wren, busy, done, error, cpu_run
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: SYNC, 12-bit length, big-endian words, checksum byte.
// Words go to RAM from address 0; the CPU is released only after a clean image.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.master bus
);

  localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e            state_q,    state_d;
  logic [11:0]       last_idx_q, last_idx_d;   // N-1, from LEN_HI[3:0]:LEN_LO
  logic [11:0]       word_idx_q, word_idx_d;
  logic [7:0]        hi_q,       hi_d;
  logic [7:0]        sum_q,      sum_d;
  logic [TMO_W-1:0]  tmo_q,      tmo_d;
  logic [15:0]       ram_data_q, ram_data_d;
  logic [11:0]       ram_addr_q, ram_addr_d;
  logic              ram_wren_q, ram_wren_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              error_q,    error_d;

  logic [7:0] sum_plus;
  logic       in_frame;

  assign sum_plus = sum_q + bus.rx_data;
  assign in_frame = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    last_idx_d = last_idx_q;
    word_idx_d = word_idx_q;
    hi_d       = hi_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    ram_data_d = ram_data_q;
    ram_addr_d = ram_addr_q;
    ram_wren_d = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_d    = S_LEN_HI;
          sum_d      = '0;
          word_idx_d = '0;
          tmo_d      = '0;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7:4] != 4'h0) begin
            state_d = S_ERROR;
          end else begin
            last_idx_d[11:8] = bus.rx_data[3:0];
            sum_d            = sum_plus;
            state_d          = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          last_idx_d[7:0] = bus.rx_data;
          sum_d           = sum_plus;
          word_idx_d      = '0;
          state_d         = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (bus.rx_valid) begin
          hi_d    = bus.rx_data;
          sum_d   = sum_plus;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (bus.rx_valid) begin
          sum_d      = sum_plus;
          ram_data_d = {hi_q, bus.rx_data};
          ram_addr_d = word_idx_q;
          ram_wren_d = 1'b1;
          // The index stops at N-1, so a 4096-word image never wraps back to 0.
          if (word_idx_q == last_idx_q) begin
            state_d = S_CHECK;
          end else begin
            word_idx_d = word_idx_q + 12'd1;
            state_d    = S_DATA_HI;
          end
        end
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          state_d = (sum_plus == 8'h00) ? S_DONE : S_ERROR;
        end
      end
      default: ;  // S_DONE holds until reset and ignores the byte stream
    endcase

    // Inter-byte watchdog; a byte landing in the expiry cycle takes priority.
    if (in_frame) begin
      if (bus.rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d = S_ERROR;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    busy_d  = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_idx_q <= '0;
      word_idx_q <= '0;
      hi_q       <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      ram_data_q <= '0;
      ram_addr_q <= '0;
      ram_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      word_idx_q <= word_idx_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      ram_data_q <= ram_data_d;
      ram_addr_q <= ram_addr_d;
      ram_wren_q <= ram_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.ram_data = ram_data_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wren = ram_wren_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.cpu_run  = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: valid/corrupt frames, length and timeout
// errors, a full 4096-word image and a reset in the middle of a load.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  prog_loader_if bus ();

  prog_loader #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Write log ({addr, data}) and back-to-back write-enable detector.
  logic [27:0] wr_log[$];
  int          consec_cnt = 0;
  logic        prev_wren  = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.ram_wren) begin
      wr_log.push_back({bus.ram_addr, bus.ram_data});
      if (prev_wren) consec_cnt++;
    end
    prev_wren = bus.ram_wren;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {busy, done, error, cpu_run}
  task automatic check_status(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus.busy, bus.done, bus.error, bus.cpu_run}, {28'd0, exp});
  endtask

  task automatic check_write(input string tag, input int idx, input logic [11:0] addr,
                             input logic [15:0] data);
    logic [27:0] entry;
    entry = (idx < wr_log.size()) ? wr_log[idx] : 28'hxxxxxxx;
    check(tag, {4'd0, entry}, {4'd0, addr, data});
  endtask

  // Called at a negedge; presents the byte for one cycle, returns at the next negedge.
  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'(i * 7) ^ 16'hC35A;
  endfunction

  initial begin
    int          base;
    int          bad_words;
    logic [7:0]  sum;
    logic [15:0] w;

    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ram_data", {16'd0, bus.ram_data}, 32'd0);
    check("rst_ram_addr", {20'd0, bus.ram_addr}, 32'd0);
    check("rst_ram_wren", {31'd0, bus.ram_wren}, 32'd0);
    check_status("rst_status", 4'b0000);
    rst_n = 1'b1;

    // Noise then a valid 3-word frame
    @(negedge clk);
    base = wr_log.size();
    put(8'h00); put(8'h55);
    check_status("noise_ignored", 4'b0000);
    put(8'hA5);
    check_status("busy_after_sync", 4'b1000);
    put(8'h00); put(8'h02);
    put(8'h80); put(8'h20); put(8'h81); put(8'h03); put(8'h48); put(8'h00);
    put(8'h92);
    check_status("good_frame_done", 4'b0101);
    check("good_wr_count", wr_log.size() - base, 3);
    check_write("good_wr0", base + 0, 12'h000, 16'h8020);
    check_write("good_wr1", base + 1, 12'h001, 16'h8103);
    check_write("good_wr2", base + 2, 12'h002, 16'h4800);
    put(8'hA5); put(8'h00);
    check_status("done_ignores_sync", 4'b0101);
    check("done_no_writes", wr_log.size() - base, 3);

    // Bad checksum, then recovery with a valid frame
    do_reset();
    base = wr_log.size();
    put(8'hA5); put(8'h00); put(8'h02);
    put(8'h80); put(8'h20); put(8'h81); put(8'h03); put(8'h48); put(8'h00);
    put(8'h93);
    check_status("bad_chk_error", 4'b0010);
    check("bad_chk_wr_count", wr_log.size() - base, 3);
    put(8'hA5);
    check_status("error_cleared_by_sync", 4'b1000);
    put(8'h00); put(8'h02);
    put(8'h80); put(8'h20); put(8'h81); put(8'h03); put(8'h48); put(8'h00);
    put(8'h92);
    check_status("recovered_done", 4'b0101);
    check("recovered_wr_count", wr_log.size() - base, 6);
    check_write("recovered_wr2", base + 5, 12'h002, 16'h4800);

    // Length high nibble set
    do_reset();
    base = wr_log.size();
    put(8'hA5); put(8'h10);
    check_status("len_hi_error", 4'b0010);
    repeat (2) @(negedge clk);
    check("len_hi_no_writes", wr_log.size() - base, 0);

    // Timeout: 15 idle cycles still loading, 16th expires
    do_reset();
    base = wr_log.size();
    put(8'hA5); put(8'h00); put(8'h00); put(8'h12);
    repeat (15) @(negedge clk);
    check_status("tmo_not_yet", 4'b1000);
    @(negedge clk);
    check_status("tmo_expired", 4'b0010);
    // Restart from ERROR; byte exactly in the expiry cycle keeps the load alive
    put(8'hA5); put(8'h00); put(8'h00); put(8'h12);
    repeat (15) @(negedge clk);
    put(8'h34);
    check_status("tmo_byte_at_expiry", 4'b1000);
    put(8'hBA);
    check_status("tmo_recovered_done", 4'b0101);
    check("tmo_wr_count", wr_log.size() - base, 1);
    check_write("tmo_wr0", base, 12'h000, 16'h1234);

    // Full 4096-word image, one byte per cycle
    do_reset();
    base = wr_log.size();
    sum  = 8'h0F + 8'hFF;
    put(8'hA5); put(8'h0F); put(8'hFF);
    for (int i = 0; i < 4096; i++) begin
      w   = word_of(i);
      sum = sum + w[15:8] + w[7:0];
      put(w[15:8]); put(w[7:0]);
    end
    put(8'h00 - sum);
    check_status("full_done", 4'b0101);
    check("full_wr_count", wr_log.size() - base, 4096);
    bad_words = 0;
    for (int i = 0; i < 4096; i++) begin
      if (base + i >= wr_log.size() || wr_log[base + i] !== {12'(i), word_of(i)}) bad_words++;
    end
    check("full_words_in_order", bad_words, 0);
    check("full_last_addr", {20'd0, bus.ram_addr}, 32'h0000_0FFF);

    // Reset in the middle of a load
    do_reset();
    base = wr_log.size();
    put(8'hA5); put(8'h00); put(8'h02);
    put(8'h80); put(8'h20); put(8'h81); put(8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ram_data", {16'd0, bus.ram_data}, 32'd0);
    check("midrst_ram_addr", {20'd0, bus.ram_addr}, 32'd0);
    check("midrst_ram_wren", {31'd0, bus.ram_wren}, 32'd0);
    check_status("midrst_status", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h48); put(8'h00); put(8'h92);
    check_status("midrst_idle_after", 4'b0000);
    check("midrst_wr_count", wr_log.size() - base, 2);
    put(8'hA5); put(8'h00); put(8'h00); put(8'h12); put(8'h34); put(8'hBA);
    check_status("midrst_fresh_done", 4'b0101);
    check("midrst_fresh_wr_count", wr_log.size() - base, 3);
    check_write("midrst_fresh_wr", base + 2, 12'h000, 16'h1234);

    repeat (2) @(negedge clk);
    check("no_consecutive_wren", consec_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
